// File: rtl/cva6_lsu_mq_model_if.sv
// rtl/cva6_lsu_mq_model_if.sv - op/response/status bundle for cva6_lsu_mq_model
//
// Purpose: groups the memory-op offer, the response strobes and the status
// outputs of cva6_lsu_mq_model into one interface.
//   master modport : drives instr_i, is_load_i, instr_valid_i, load_mem_resp_i,
//                    store_mem_resp_i; observes the remaining signals
//   slave  modport : the model itself (mirror image of master)
interface cva6_lsu_mq_model_if #(
  parameter int ADDR_W   = 32,
  parameter int LQ_DEPTH = 4,
  parameter int SQ_DEPTH = 4
);
  logic [ADDR_W-1:0]            instr_i;
  logic                         is_load_i;
  logic                         instr_valid_i;
  logic                         load_mem_resp_i;
  logic                         store_mem_resp_i;
  logic                         ready_o;
  logic [$clog2(LQ_DEPTH):0]    lq_cnt_o;
  logic [$clog2(SQ_DEPTH):0]    sq_cnt_o;
  logic                         load_done_o;
  logic [ADDR_W-1:0]            load_done_addr_o;
  logic                         resp_err_o;

  modport master (
    output instr_i, is_load_i, instr_valid_i, load_mem_resp_i, store_mem_resp_i,
    input  ready_o, lq_cnt_o, sq_cnt_o, load_done_o, load_done_addr_o, resp_err_o
  );

  modport slave (
    input  instr_i, is_load_i, instr_valid_i, load_mem_resp_i, store_mem_resp_i,
    output ready_o, lq_cnt_o, sq_cnt_o, load_done_o, load_done_addr_o, resp_err_o
  );
endinterface

// File: rtl/cva6_lsu_mq_model.sv
// rtl/cva6_lsu_mq_model.sv - multi-outstanding CVA6 LSU load/store queue model
//
// Purpose: tracks up to LQ_DEPTH pending loads and SQ_DEPTH pending stores in
// two in-order FIFOs, each retired by its own memory-response strobe.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : cva6_lsu_mq_model_if.slave (op offer, response strobes, status)
// Optional feature: define CVA6_LSU_RAW_STALL_EN to stall a load whose address
// matches any pending store (read-after-write hazard).
module cva6_lsu_mq_model #(
  parameter int ADDR_W   = 32,
  parameter int LQ_DEPTH = 4,
  parameter int SQ_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cva6_lsu_mq_model_if.slave   bus
);
  localparam int LQ_PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int SQ_PW = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
  localparam int LQ_CW = $clog2(LQ_DEPTH) + 1;
  localparam int SQ_CW = $clog2(SQ_DEPTH) + 1;

  logic [ADDR_W-1:0] r_lq_mem [LQ_DEPTH];
  logic [ADDR_W-1:0] r_sq_mem [SQ_DEPTH];
  logic [LQ_PW-1:0]  r_lq_head, r_lq_tail;
  logic [SQ_PW-1:0]  r_sq_head, r_sq_tail;
  logic [LQ_CW-1:0]  r_lq_cnt;
  logic [SQ_CW-1:0]  r_sq_cnt;
  logic              r_load_done;
  logic [ADDR_W-1:0] r_load_done_addr;
  logic              r_resp_err;

  logic w_lq_full, w_sq_full, w_lq_empty, w_sq_empty;
  logic w_load_ok, w_ready;
  logic w_push_lq, w_push_sq, w_pop_lq, w_pop_sq;

  // Wrap explicitly at DEPTH-1 so a 1-entry queue keeps its pointer at 0.
  function automatic logic [LQ_PW-1:0] lq_inc(input logic [LQ_PW-1:0] p);
    return (p == LQ_PW'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [SQ_PW-1:0] sq_inc(input logic [SQ_PW-1:0] p);
    return (p == SQ_PW'(SQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_lq_full  = (r_lq_cnt == LQ_CW'(LQ_DEPTH));
  assign w_sq_full  = (r_sq_cnt == SQ_CW'(SQ_DEPTH));
  assign w_lq_empty = (r_lq_cnt == '0);
  assign w_sq_empty = (r_sq_cnt == '0);

`ifdef CVA6_LSU_RAW_STALL_EN
  // Per-slot valid bits let the hazard compare ignore stale, already-retired slots.
  logic [SQ_DEPTH-1:0] r_sq_vld;
  logic                w_raw_hit;

  always_comb begin
    w_raw_hit = 1'b0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (r_sq_vld[i] && (r_sq_mem[i] == bus.instr_i)) w_raw_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sq_vld <= '0;
    end else begin
      if (w_pop_sq)  r_sq_vld[r_sq_head] <= 1'b0;
      if (w_push_sq) r_sq_vld[r_sq_tail] <= 1'b1;
    end
  end

  assign w_load_ok = !w_lq_full && !w_raw_hit;
`else
  assign w_load_ok = !w_lq_full;
`endif

  // With no op offered, report ready unless both queues are full.
  always_comb begin
    w_ready = !(w_lq_full && w_sq_full);
    if (bus.instr_valid_i) w_ready = bus.is_load_i ? w_load_ok : !w_sq_full;
  end

  assign w_push_lq = bus.instr_valid_i && w_ready && bus.is_load_i;
  assign w_push_sq = bus.instr_valid_i && w_ready && !bus.is_load_i;
  assign w_pop_lq  = bus.load_mem_resp_i && !w_lq_empty;
  assign w_pop_sq  = bus.store_mem_resp_i && !w_sq_empty;

  // Payload storage needs no reset: the counts define which slots are live.
  always_ff @(posedge clk_i) begin
    if (w_push_lq) r_lq_mem[r_lq_tail] <= bus.instr_i;
    if (w_push_sq) r_sq_mem[r_sq_tail] <= bus.instr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lq_head        <= '0;
      r_lq_tail        <= '0;
      r_sq_head        <= '0;
      r_sq_tail        <= '0;
      r_lq_cnt         <= '0;
      r_sq_cnt         <= '0;
      r_load_done      <= 1'b0;
      r_load_done_addr <= '0;
      r_resp_err       <= 1'b0;
    end else begin
      if (w_push_lq) r_lq_tail <= lq_inc(r_lq_tail);
      if (w_pop_lq)  r_lq_head <= lq_inc(r_lq_head);
      if (w_push_sq) r_sq_tail <= sq_inc(r_sq_tail);
      if (w_pop_sq)  r_sq_head <= sq_inc(r_sq_head);

      case ({w_push_lq, w_pop_lq})
        2'b10:   r_lq_cnt <= r_lq_cnt + 1'b1;
        2'b01:   r_lq_cnt <= r_lq_cnt - 1'b1;
        default: r_lq_cnt <= r_lq_cnt;
      endcase
      case ({w_push_sq, w_pop_sq})
        2'b10:   r_sq_cnt <= r_sq_cnt + 1'b1;
        2'b01:   r_sq_cnt <= r_sq_cnt - 1'b1;
        default: r_sq_cnt <= r_sq_cnt;
      endcase

      r_load_done <= w_pop_lq;
      if (w_pop_lq) r_load_done_addr <= r_lq_mem[r_lq_head];
      r_resp_err  <= (bus.load_mem_resp_i && w_lq_empty) ||
                     (bus.store_mem_resp_i && w_sq_empty);
    end
  end

  assign bus.ready_o          = w_ready;
  assign bus.lq_cnt_o         = r_lq_cnt;
  assign bus.sq_cnt_o         = r_sq_cnt;
  assign bus.load_done_o      = r_load_done;
  assign bus.load_done_addr_o = r_load_done_addr;
  assign bus.resp_err_o       = r_resp_err;
endmodule

// File: tb/tb_cva6_lsu_mq_model.sv
// tb/tb_cva6_lsu_mq_model.sv - directed self-checking bench for cva6_lsu_mq_model
module tb_cva6_lsu_mq_model;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  cva6_lsu_mq_model_if #(.ADDR_W(32), .LQ_DEPTH(4), .SQ_DEPTH(4)) bus ();

  cva6_lsu_mq_model #(.ADDR_W(32), .LQ_DEPTH(4), .SQ_DEPTH(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic ld, input logic [31:0] a);
    bus.instr_valid_i = 1'b1;
    bus.is_load_i     = ld;
    bus.instr_i       = a;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    bus.instr_i = '0;
    bus.is_load_i = 1'b0;
    bus.instr_valid_i = 1'b0;
    bus.load_mem_resp_i = 1'b0;
    bus.store_mem_resp_i = 1'b0;
    step();
    step();

    // reset state
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_lq_cnt", 32'(bus.lq_cnt_o), 32'd0);
    chk("rst_sq_cnt", 32'(bus.sq_cnt_o), 32'd0);
    chk("rst_done", 32'(bus.load_done_o), 32'd0);
    chk("rst_done_addr", bus.load_done_addr_o, 32'd0);
    chk("rst_err", 32'(bus.resp_err_o), 32'd0);
    rst_n = 1'b1;
    step();

    // four back-to-back loads fill the LQ
    offer(1'b1, 32'hcad); step();
    offer(1'b1, 32'hcae); step();
    offer(1'b1, 32'hcaf); step();
    offer(1'b1, 32'hcb0); step();
    chk("fill_lq_cnt", 32'(bus.lq_cnt_o), 32'd4);
    chk("full_load_ready", 32'(bus.ready_o), 32'd0);
    bus.is_load_i = 1'b0; #1;
    chk("full_store_ready", 32'(bus.ready_o), 32'd1);
    bus.instr_valid_i = 1'b0; #1;
    chk("full_idle_ready", 32'(bus.ready_o), 32'd1);

    // retire in order
    bus.load_mem_resp_i = 1'b1;
    step();
    chk("ret0_done", 32'(bus.load_done_o), 32'd1);
    chk("ret0_addr", bus.load_done_addr_o, 32'hcad);
    chk("ret0_cnt", 32'(bus.lq_cnt_o), 32'd3);
    step();
    chk("ret1_addr", bus.load_done_addr_o, 32'hcae);
    step();
    chk("ret2_addr", bus.load_done_addr_o, 32'hcaf);
    step();
    chk("ret3_addr", bus.load_done_addr_o, 32'hcb0);
    chk("ret3_cnt", 32'(bus.lq_cnt_o), 32'd0);
    bus.load_mem_resp_i = 1'b0;
    step();
    chk("ret_done_low", 32'(bus.load_done_o), 32'd0);
    chk("ret_err_low", 32'(bus.resp_err_o), 32'd0);

    // full LQ: response and load offer in the same cycle -> load not taken
    offer(1'b1, 32'h100); step();
    offer(1'b1, 32'h101); step();
    offer(1'b1, 32'h102); step();
    offer(1'b1, 32'h103); step();
    offer(1'b1, 32'h200);
    bus.load_mem_resp_i = 1'b1; #1;
    chk("full_pop_ready", 32'(bus.ready_o), 32'd0);
    step();
    chk("full_pop_cnt", 32'(bus.lq_cnt_o), 32'd3);
    chk("full_pop_addr", bus.load_done_addr_o, 32'h100);
    bus.load_mem_resp_i = 1'b0; #1;
    chk("freed_ready", 32'(bus.ready_o), 32'd1);
    step();
    chk("refill_cnt", 32'(bus.lq_cnt_o), 32'd4);
    bus.instr_valid_i = 1'b0;
    bus.load_mem_resp_i = 1'b1;
    step();
    chk("pop_101", bus.load_done_addr_o, 32'h101);
    offer(1'b1, 32'h202);
    step();
    chk("pushpop_cnt", 32'(bus.lq_cnt_o), 32'd3);
    chk("pushpop_addr", bus.load_done_addr_o, 32'h102);
    bus.instr_valid_i = 1'b0;
    step();
    chk("drain_103", bus.load_done_addr_o, 32'h103);
    step();
    chk("drain_200", bus.load_done_addr_o, 32'h200);
    step();
    chk("drain_202", bus.load_done_addr_o, 32'h202);
    chk("drain_cnt", 32'(bus.lq_cnt_o), 32'd0);
    bus.load_mem_resp_i = 1'b0;

    // store response on empty SQ
    bus.store_mem_resp_i = 1'b1;
    step();
    chk("err_pulse", 32'(bus.resp_err_o), 32'd1);
    chk("err_sq_cnt", 32'(bus.sq_cnt_o), 32'd0);
    bus.store_mem_resp_i = 1'b0;
    step();
    chk("err_clear", 32'(bus.resp_err_o), 32'd0);

    // load behind a store to the same address
    offer(1'b0, 32'hcad); step();
    chk("raw_sq_cnt", 32'(bus.sq_cnt_o), 32'd1);
    offer(1'b1, 32'hcad); #1;
`ifdef CVA6_LSU_RAW_STALL_EN
    chk("raw_stall_ready", 32'(bus.ready_o), 32'd0);
    step();
    chk("raw_stall_lq", 32'(bus.lq_cnt_o), 32'd0);
    bus.store_mem_resp_i = 1'b1;
    step();
    chk("raw_store_ret", 32'(bus.sq_cnt_o), 32'd0);
    chk("raw_still_lq", 32'(bus.lq_cnt_o), 32'd0);
    bus.store_mem_resp_i = 1'b0; #1;
    chk("raw_release_ready", 32'(bus.ready_o), 32'd1);
    step();
    chk("raw_accept_lq", 32'(bus.lq_cnt_o), 32'd1);
    bus.instr_valid_i = 1'b0;
`else
    chk("noraw_ready", 32'(bus.ready_o), 32'd1);
    step();
    chk("noraw_lq", 32'(bus.lq_cnt_o), 32'd1);
    bus.instr_valid_i = 1'b0;
    bus.store_mem_resp_i = 1'b1;
    step();
    chk("noraw_store_ret", 32'(bus.sq_cnt_o), 32'd0);
    bus.store_mem_resp_i = 1'b0;
`endif
    bus.load_mem_resp_i = 1'b1;
    step();
    chk("raw_load_addr", bus.load_done_addr_o, 32'hcad);
    chk("raw_load_cnt", 32'(bus.lq_cnt_o), 32'd0);
    bus.load_mem_resp_i = 1'b0;
    step();

    // asynchronous reset with entries pending
    offer(1'b1, 32'h10); step();
    offer(1'b0, 32'h20); step();
    offer(1'b1, 32'h11); step();
    offer(1'b0, 32'h21); step();
    offer(1'b0, 32'h22); step();
    bus.instr_valid_i = 1'b0;
    chk("pend_lq", 32'(bus.lq_cnt_o), 32'd2);
    chk("pend_sq", 32'(bus.sq_cnt_o), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lq", 32'(bus.lq_cnt_o), 32'd0);
    chk("arst_sq", 32'(bus.sq_cnt_o), 32'd0);
    chk("arst_ready", 32'(bus.ready_o), 32'd1);
    #2 rst_n = 1'b1;
    step();
    bus.load_mem_resp_i = 1'b1;
    step();
    chk("post_rst_err", 32'(bus.resp_err_o), 32'd1);
    chk("post_rst_done", 32'(bus.load_done_o), 32'd0);
    chk("post_rst_lq", 32'(bus.lq_cnt_o), 32'd0);
    bus.load_mem_resp_i = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
